// File: rtl/ram_port_pkg.sv
// Shared constants and the round-robin pick helper for the RAM port controller.
package ram_port_pkg;
    localparam int NPORT      = 4;
    localparam int RSP_DEPTH  = 2;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MASK_W = 4;
    localparam int PTR_W      = $clog2(NPORT);
    localparam int OCC_W      = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic             hit;
        logic [PTR_W-1:0] idx;
    } rr_grant_t;

    // First requester at or after ptr, wrapping; NPORT is a power of two.
    function automatic rr_grant_t rr_pick(input logic [NPORT-1:0] req,
                                          input logic [PTR_W-1:0] ptr);
        rr_grant_t        g;
        logic [PTR_W-1:0] idx;
        g = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx = ptr + PTR_W'(i);
            if (!g.hit && req[idx]) begin
                g.hit = 1'b1;
                g.idx = idx;
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/ram_rsp_fifo.sv
// Two-entry read response buffer with valid/ready on both sides and occupancy out.
module ram_rsp_fifo
    import ram_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [OCC_W-1:0]  occupancy
);
    localparam int FP_W = $clog2(RSP_DEPTH);

    logic [RSP_DEPTH-1:0][DATA_W-1:0] mem;
    logic [FP_W-1:0]                  wr_ptr;
    logic [FP_W-1:0]                  rd_ptr;
    logic                             do_push;
    logic                             do_pop;

    assign push_ready = (occupancy != OCC_W'(RSP_DEPTH));
    assign pop_valid  = (occupancy != '0);
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_valid & pop_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + FP_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + FP_W'(1);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ram_port_ctrl.sv
// Shares one RAM write port between four round-robin requesters and fronts four
// registered RAM read ports with credit-controlled, in-order response buffers.
module ram_port_ctrl
    import ram_port_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DEF_MASK_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPORT-1:0]               r_req_valid,
    output logic [NPORT-1:0]               r_req_ready,
    input  logic [NPORT-1:0][ADDR_W-1:0]   r_req_addr,
    output logic [NPORT-1:0]               r_rsp_valid,
    input  logic [NPORT-1:0]               r_rsp_ready,
    output logic [NPORT-1:0][DATA_W-1:0]   r_rsp_data,
    input  logic [NPORT-1:0]               w_req_valid,
    output logic [NPORT-1:0]               w_req_ready,
    input  logic [NPORT-1:0][ADDR_W-1:0]   w_req_addr,
    input  logic [NPORT-1:0][DATA_W-1:0]   w_req_data,
    input  logic [NPORT-1:0][MASK_W-1:0]   w_req_mask,
    output logic                           ram_wr_en,
    output logic [MASK_W-1:0]              ram_wr_mask,
    output logic [ADDR_W-1:0]              ram_wr_addr,
    output logic [DATA_W-1:0]              ram_wr_data,
    output logic [NPORT-1:0]               ram_rd_en,
    output logic [NPORT-1:0][ADDR_W-1:0]   ram_rd_addr,
    input  logic [NPORT-1:0][DATA_W-1:0]   ram_rd_data
);
    logic [PTR_W-1:0] wr_ptr;
    rr_grant_t        gnt;

    always_comb gnt = rr_pick(w_req_valid, wr_ptr);

    always_ff @(posedge clk) begin
        if (reset)
            wr_ptr <= '0;
        else if (gnt.hit)
            wr_ptr <= gnt.idx + PTR_W'(1);
    end

    always_comb begin
        w_req_ready = '0;
        if (!reset && gnt.hit)
            w_req_ready[gnt.idx] = 1'b1;
    end

    assign ram_wr_en   = !reset && (|w_req_valid);
    assign ram_wr_addr = w_req_addr[gnt.idx];
    assign ram_wr_data = w_req_data[gnt.idx];
    assign ram_wr_mask = w_req_mask[gnt.idx];

    for (genvar j = 0; j < NPORT; j++) begin : g_ch
        logic             inflight;
        logic             hazard;
        logic             pop;
        logic             push_ready;
        logic [OCC_W-1:0] occ;
        logic [OCC_W-1:0] used;

        // A same-cycle write to this address must land before the read samples the RAM.
        assign hazard = ram_wr_en && (ram_wr_addr == r_req_addr[j]);
        assign pop    = r_rsp_valid[j] & r_rsp_ready[j];
        // The slot freed by this cycle's pop counts as credit so reads can issue every cycle.
        assign used   = occ + OCC_W'(inflight) - OCC_W'(pop);

        assign r_req_ready[j] = !reset && !hazard && (used < OCC_W'(RSP_DEPTH));
        assign ram_rd_en[j]   = r_req_valid[j] & r_req_ready[j];
        assign ram_rd_addr[j] = r_req_addr[j];

        always_ff @(posedge clk) begin
            if (reset)
                inflight <= 1'b0;
            else
                inflight <= ram_rd_en[j];
        end

        ram_rsp_fifo #(.DATA_W(DATA_W)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_valid (inflight & push_ready),
            .push_ready (push_ready),
            .push_data  (ram_rd_data[j]),
            .pop_valid  (r_rsp_valid[j]),
            .pop_ready  (r_rsp_ready[j]),
            .pop_data   (r_rsp_data[j]),
            .occupancy  (occ)
        );
    end
endmodule
